// File: rtl/fb_dump_ctrl.sv
// Frame-buffer dump controller: on a trigger, waits for the next frame start,
// freezes capture writes, reads the RAM word by word and streams each word
// to the UART as four bytes (LSB first). Entirely in the pixclk domain.
module fb_dump_ctrl #(
  parameter int unsigned WORDS = 76800,
  parameter int unsigned AW    = 17
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          trigger,
  input  logic          abort,
  input  logic          frame_start,
  input  logic          wr_en_in,
  output logic          wr_en_out,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [AW+1:0] tx_addr,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_READ,
    S_FETCH,
    S_SEND,
    S_HOLD,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          trig_q;
  logic          freeze_q, freeze_d;
  logic [AW-1:0] word_q, word_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   sr_q, sr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [AW+1:0] tx_addr_q, tx_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tx_start_c;

  // Next-state, datapath updates and the send handshake; abort overrides all.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_d     = byte_q;
    sr_d       = sr_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_addr_d  = tx_addr_q;
    tx_start_c = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger && !trig_q) state_d = S_ARM;
        end
        S_ARM: begin
          if (frame_start) begin
            state_d   = S_READ;
            word_d    = '0;
            byte_d    = '0;
            rd_addr_d = '0;
          end
        end
        S_READ: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          // RAM output is valid now; byte 0 is presented on entry to SEND
          sr_d      = rd_data;
          tx_data_d = rd_data[7:0];
          tx_addr_d = {word_q, byte_q};
          state_d   = S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_start_c = 1'b1;
            sr_d       = {8'h00, sr_q[31:8]};
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (byte_q != 2'd3) begin
            byte_d    = byte_q + 2'd1;
            tx_data_d = sr_q[7:0];
            tx_addr_d = {word_q, byte_q + 2'd1};
            state_d   = S_SEND;
          end else if (word_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            word_d    = word_q + AW'(1);
            byte_d    = '0;
            rd_addr_d = word_q + AW'(1);
            state_d   = S_READ;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Status flags follow the state being entered so they are registered yet aligned.
  always_comb begin
    freeze_d = (state_d == S_READ) || (state_d == S_FETCH) || (state_d == S_SEND) ||
               (state_d == S_HOLD) || (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      trig_q    <= 1'b0;
      freeze_q  <= 1'b0;
      word_q    <= '0;
      byte_q    <= '0;
      sr_q      <= '0;
      rd_addr_q <= '0;
      tx_data_q <= '0;
      tx_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trigger;
      freeze_q  <= freeze_d;
      word_q    <= word_d;
      byte_q    <= byte_d;
      sr_q      <= sr_d;
      rd_addr_q <= rd_addr_d;
      tx_data_q <= tx_data_d;
      tx_addr_q <= tx_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Gate capture writes from the accepted frame start until the dump ends.
  always_comb begin
    wr_en_out = wr_en_in & ~(freeze_q | ((state_q == S_ARM) & frame_start));
  end

  // tx_start must be seen by the UART in the SEND cycle, so it is not registered.
  assign tx_start = tx_start_c;
  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_addr  = tx_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fb_dump_ctrl.sv
// Scoreboard bench for fb_dump_ctrl with a 4-word RAM and a UART ready model.
module tb_fb_dump_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned TAW   = AW + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           trigger = 1'b0;
  logic           abort = 1'b0;
  logic           frame_start = 1'b0;
  logic           wr_en_in = 1'b1;
  logic           wr_en_out;
  logic [AW-1:0]  rd_addr;
  logic [31:0]    rd_data = 32'h0;
  logic           tx_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [TAW-1:0] tx_addr;
  logic           busy;
  logic           done;

  fb_dump_ctrl #(.WORDS(WORDS), .AW(AW)) dut (
    .pixclk      (clk),
    .reset       (rst_n),
    .trigger     (trigger),
    .abort       (abort),
    .frame_start (frame_start),
    .wr_en_in    (wr_en_in),
    .wr_en_out   (wr_en_out),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_addr     (tx_addr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // RAM port B: one-cycle read latency; byte n of the image holds value n.
  logic [31:0] mem [WORDS];
  initial begin
    mem[0] = 32'h03020100;
    mem[1] = 32'h07060504;
    mem[2] = 32'h0B0A0908;
    mem[3] = 32'h0F0E0D0C;
  end
  always @(posedge clk) rd_data <= mem[rd_addr];

  // UART: drops ready for bp cycles after each accepted start.
  int bp = 0;
  int ucnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt <= 0;
    else if (tx_start && bp > 0) ucnt <= bp;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign tx_ready = (ucnt == 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]     d;
    logic [TAW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int first_start_cyc = -1;
  int last_start_cyc = -1;
  int s0, d0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      e.d = 8'(i);
      e.a = TAW'(i);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every tx_start pops the next expected byte.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      check("start_while_ready", 32'(tx_ready), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_start: got addr %0d data %0h, required no start", tx_addr, tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_e.d));
        check("tx_addr", 32'(tx_addr), 32'(mon_e.a));
      end
      start_cnt++;
      if (first_start_cyc < 0) first_start_cyc = cyc;
      last_start_cyc = cyc;
    end
    if (done === 1'b1) done_cnt++;
  end

  // Full 16-byte dump with write-gating and optional latency checks.
  task automatic run_dump(input int bpv, input bit retrig, input bit timing);
    int f, n, viol, ss, dd;
    bp = bpv;
    push_range(0, 15);
    ss = start_cnt;
    dd = done_cnt;
    first_start_cyc = -1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    @(negedge clk);
    check("busy_arm", 32'(busy), 32'd1);
    check("wr_en_arm", 32'(wr_en_out), 32'd1);
    tick();
    frame_start = 1'b1;
    @(negedge clk);
    f = cyc;
    check("wr_en_fs", 32'(wr_en_out), 32'd0);
    tick();
    frame_start = 1'b0;
    n = 0;
    viol = 0;
    do begin
      @(negedge clk);
      n++;
      if (wr_en_out !== 1'b0) viol++;
      if (retrig && n == 12) trigger = 1'b1;
      if (retrig && n == 14) trigger = 1'b0;
    end while (done !== 1'b1 && n < 3000);
    check("done_seen", 32'(done), 32'd1);
    check("wr_gate_violations", 32'(viol), 32'd0);
    if (timing) begin
      check("first_start_lat", 32'(first_start_cyc - f), 32'd3);
      check("last_start_lat", 32'(last_start_cyc - f), 32'd39);
      check("done_lat", 32'(cyc - f), 32'd41);
    end
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("wr_en_after_done", 32'(wr_en_out), 32'd1);
    check("done_single", 32'(done), 32'd0);
    check("bytes_sent", 32'(start_cnt - ss), 32'd16);
    check("done_count", 32'(done_cnt - dd), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // reset values
    tick();
    tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_addr", 32'(tx_addr), 32'd0);
    check("rst_wr_pass1", 32'(wr_en_out), 32'd1);
    wr_en_in = 1'b0;
    #1;
    check("rst_wr_pass0", 32'(wr_en_out), 32'd0);
    wr_en_in = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // full dump, no backpressure, with write gating
    run_dump(0, 1'b0, 1'b1);

    // UART backpressure
    run_dump(10, 1'b0, 1'b0);
    bp = 0;
    repeat (12) tick();

    // abort during byte 2 of word 1
    push_range(0, 5);
    s0 = start_cnt;
    d0 = done_cnt;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (16) tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_start_suppressed", 32'(tx_start), 32'd0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(wr_en_out), 32'd1);
    repeat (30) tick();
    check("abort_bytes", 32'(start_cnt - s0), 32'd6);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    run_dump(0, 1'b0, 1'b1);

    // second trigger during dump is ignored
    run_dump(0, 1'b1, 1'b1);

    // trigger edge and abort together in IDLE
    trigger = 1'b1;
    abort = 1'b1;
    tick();
    trigger = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("collision_idle", 32'(busy), 32'd0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (20) tick();
    check("collision_still_idle", 32'(busy), 32'd0);

    // asynchronous reset in FETCH of word 1
    push_range(0, 3);
    s0 = start_cnt;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (11) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tx_start", 32'(tx_start), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_tx_addr", 32'(tx_addr), 32'd0);
    check("arst_rd_addr", 32'(rd_addr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_wr_en", 32'(wr_en_out), 32'd1);
    check("arst_bytes", 32'(start_cnt - s0), 32'd4);
    check("arst_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (20) tick();
    check("arst_needs_trigger", 32'(busy), 32'd0);
    run_dump(0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_dump_ctrl.md
# fb_dump_ctrl

Frame-buffer dump controller between the MIPI capture path, the dual-clock frame-buffer RAM, and the UART debug transmitter. On a trigger it waits for the next frame start, freezes capture writes into the RAM, and reads the buffer word by word. Each 32-bit word is split into four bytes and sent to the UART through a start/ready handshake. After the last byte it releases the freeze. It replaces the ad-hoc serial-debug sequencing in the top file and sits entirely in the `pixclk` domain.

## Interface

Parameters:
- `WORDS`, 76800: number of 32-bit words to dump (640x480 8-bit pixels).
- `AW`, 17: word-address width; requires `WORDS <= 2**AW`.

Ports:
- `pixclk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  dump request; level input, rising edge detected.
- `abort`  in  1  synchronous abort; level input, acted on in any cycle it is high.
- `frame_start`  in  1  single-cycle pulse from the capture path, already synchronous to `pixclk`.
- `wr_en_in`  in  1  capture write enable.
- `wr_en_out`  out  1  gated write enable to RAM port A.
- `rd_addr`  out  AW  registered word address to RAM port B.
- `rd_data`  in  32  RAM port B data; valid one cycle after `rd_addr`.
- `tx_ready`  in  1  UART idle flag.
- `tx_start`  out  1  single-cycle send pulse.
- `tx_data`  out  8  byte to send; held stable from `tx_start` until the next `tx_start`.
- `tx_addr`  out  AW+2  byte address `{word_addr, byte_idx}` of `tx_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse when the last byte's `tx_start` has been issued.

## Operation

States: IDLE, ARM, READ, FETCH, SEND, HOLD, DONE.

- **IDLE**
  - On a rising edge of `trigger` (registered previous value, 0 at reset), go to ARM.
  - Edges of `trigger` in any other state are ignored.
- **ARM**
  - Wait for `frame_start`.
  - In the `frame_start` cycle, `freeze` is asserted combinationally.
  - Go to READ with `word_addr`=0 and `byte_idx`=0.
- **READ**
  - `rd_addr` = `word_addr` (registered).
  - Go to FETCH.
- **FETCH**
  - `rd_data` is valid in this cycle; capture it into a 32-bit shift register.
  - Go to SEND.
- **SEND**
  - Wait until `tx_ready`=1.
  - Then pulse `tx_start` for one cycle, with `tx_data` = shift register [7:0] and `tx_addr` = `{word_addr, byte_idx}`.
  - Shift the register right by 8 and go to HOLD.
- **HOLD**
  - Exactly one cycle; `tx_ready` is ignored, giving the UART time to drop it.
  - If `byte_idx` < 3: increment it and go to SEND.
  - Else if `word_addr` = `WORDS-1`: go to DONE.
  - Else: `word_addr`+1, `byte_idx`=0, go to READ.
- **DONE**
  - Pulse `done` for one cycle, clear `freeze`, go to IDLE.

Write gating:
- `wr_en_out` = `wr_en_in` & ~(`freeze` | (ARM & `frame_start`)).
- `freeze` stays high from the `frame_start` accepted in ARM through the DONE cycle.
- Writes are therefore never interrupted mid-frame on the entry side.

Byte order: byte 0 is bits [7:0], sent first; byte 3 is bits [31:24].

Abort:
- `abort`=1 in any state: next state is IDLE, `freeze` cleared, no `done`, and any `tx_start` in that cycle is suppressed.
- `abort` wins over a simultaneous `trigger` edge, `frame_start`, or SEND handshake.

Reset values: state IDLE, `wr_en_out` = `wr_en_in` (combinational pass-through, `freeze`=0), `rd_addr`=0, `tx_start`=0, `tx_data`=0, `tx_addr`=0, `busy`=0, `done`=0, shift register 0, `word_addr`=0, `byte_idx`=0.

## Timing

- `trigger` rising at the cycle-t sample: `busy`=1 at t+1.
- `frame_start` accepted at cycle f:
  - `wr_en_out`=0 from cycle f.
  - READ at f+1, FETCH at f+2, SEND at f+3.
  - The first `tx_start` is at f+3 if `tx_ready`=1.
- With `tx_ready` held high:
  - Bytes within a word: `tx_start` every 2 cycles (SEND, HOLD).
  - Word boundary: 4 cycles (HOLD, READ, FETCH, SEND).
- `done` is asserted in the cycle after the last HOLD. `busy` and `freeze` drop in the cycle after `done`.
- `tx_ready` low in SEND: the controller stalls indefinitely, with outputs held and no timeout.
- Reset asserted mid-dump: all outputs go to reset values immediately. No `done`; writes resume.
- `word_addr` never exceeds `WORDS-1`, so there is no wrap beyond the dump.

## Test plan

1. **Full dump, no backpressure.** `WORDS`=4, RAM words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, `tx_ready`=1, trigger then `frame_start`.
   - 16 `tx_start` pulses carrying `tx_data` 0x00..0x0F with `tx_addr` 0..15.
   - One `done` pulse; `busy`=0 afterward.
2. **Write gating.** `wr_en_in`=1 throughout.
   - `wr_en_out`=1 in ARM before `frame_start`.
   - `wr_en_out`=0 from the `frame_start` cycle through DONE.
   - `wr_en_out`=1 again in the cycle after `done`.
3. **UART backpressure.** UART model drops `tx_ready` for 10 cycles after every `tx_start`.
   - Exactly one `tx_start` per ready-high period, in the same byte sequence as scenario 1.
   - No byte lost or duplicated.
4. **Abort mid-dump.** Assert `abort` for 1 cycle while sending byte 2 of word 1.
   - `busy`=0 on the next cycle, no further `tx_start`, no `done`, `wr_en_out` follows `wr_en_in`.
   - A following trigger restarts from `tx_addr` 0.
5. **Trigger while busy; trigger/abort collision.**
   - A second `trigger` edge during a dump does not restart the dump or alter the sequence.
   - A `trigger` edge in the same cycle as `abort` in IDLE leaves the state in IDLE.
6. **Async reset.** Drop `reset` mid-FETCH between clock edges.
   - Outputs reach reset values before the next `pixclk` edge.
   - After release, the dump proceeds only after a new trigger and `frame_start`.
